// File: rtl/he_pkg.sv
// Shared widths, types and state encoding for the result-streaming path.
package he_pkg;
    localparam int LOGQ = 54;
    localparam int LOGN = 13;
    localparam int N    = 1 << LOGN;

    typedef logic [LOGQ-1:0] coef_t;
    typedef logic [LOGN-1:0] addr_t;

    localparam addr_t LAST_ADDR = addr_t'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stream_state_e;

    typedef struct packed {
        logic  last;
        coef_t coef;
    } beat_t;
endpackage

// File: rtl/coef_fifo.sv
// Small shift-style FIFO of {last, coef}: entry 0 is always the head, so the
// output data and valid come straight from registers.
module coef_fifo
    import he_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  beat_t         din,
    input  logic          pop,
    output beat_t         dout,
    output logic          dout_valid,
    output logic [CW-1:0] count
);
    beat_t [DEPTH-1:0] entry_reg;
    beat_t [DEPTH-1:0] entry_next;
    logic  [CW-1:0]    count_reg;
    logic  [CW-1:0]    count_next;
    logic  [CW-1:0]    wr_idx;
    logic              head_vld_reg;

    // A same-cycle pop shifts everything down, so the write lands one slot lower.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
        wr_idx = pop ? (count_reg - 1'b1) : count_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            beat_t shift_in;
            if (gi == DEPTH - 1) begin : g_top
                assign shift_in = entry_reg[gi];
            end else begin : g_mid
                assign shift_in = entry_reg[gi + 1];
            end
            assign entry_next[gi] = (push && (wr_idx == CW'(gi))) ? din :
                                    (pop ? shift_in : entry_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_reg    <= '0;
            count_reg    <= '0;
            head_vld_reg <= 1'b0;
        end else begin
            entry_reg    <= entry_next;
            count_reg    <= count_next;
            head_vld_reg <= (count_next != '0);
        end
    end

    assign dout       = entry_reg[0];
    assign dout_valid = head_vld_reg;
    assign count      = count_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_reg == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> head_vld_reg);
endmodule

// File: rtl/pwm_result_streamer.sv
// Streams a finished result polynomial out of the selected result BRAM bank in
// index order, hiding BRAM latency behind a credit-tracked output FIFO.
module pwm_result_streamer
    import he_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            bank_sel,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] bram_rd_addr,
    input  logic [LOGQ-1:0] bram_rd_data0,
    input  logic [LOGQ-1:0] bram_rd_data1,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [LOGQ-1:0] m_data,
    output logic            m_last
);
    localparam int CREDIT_W = $clog2(FIFO_DEPTH + 2);
    localparam int OCC_W    = $clog2(FIFO_DEPTH + 1);

    generate
        if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
            $error("FIFO_DEPTH must be at least RD_LAT+1");
        end
    endgenerate

    stream_state_e        state_reg;
    logic                 bank_reg;
    logic                 busy_reg;
    logic                 done_reg;
    addr_t                addr_reg;
    logic                 issue_vld_reg;
    logic                 issue_last_reg;
    logic [CREDIT_W-1:0]  credit_reg;
    logic [RD_LAT-1:0]    tag_vld_reg;
    logic [RD_LAT-1:0]    tag_vld_next;
    logic [RD_LAT-1:0]    tag_last_reg;
    logic [RD_LAT-1:0]    tag_last_next;

    logic                 pop;
    logic                 push;
    logic                 can_issue;
    logic                 issue;
    beat_t                push_beat;
    beat_t                head;
    logic                 head_vld;
    logic [OCC_W-1:0]     fifo_count;

    // Credits count reads in flight plus FIFO occupancy; a pop this cycle
    // frees its slot in time for this cycle's issue decision.
    assign pop       = head_vld && m_ready;
    assign can_issue = credit_reg < (CREDIT_W'(FIFO_DEPTH) + CREDIT_W'(pop));
    assign issue     = can_issue &&
                       (((state_reg == IDLE) && start) || (state_reg == ISSUE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bank_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            issue_vld_reg  <= 1'b0;
            issue_last_reg <= 1'b0;
            credit_reg     <= '0;
        end else begin
            done_reg       <= 1'b0;
            issue_vld_reg  <= 1'b0;
            issue_last_reg <= 1'b0;
            credit_reg     <= credit_reg + CREDIT_W'(issue) - CREDIT_W'(pop);
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= ISSUE;
                        bank_reg       <= bank_sel;
                        busy_reg       <= 1'b1;
                        addr_reg       <= '0;
                        issue_vld_reg  <= 1'b1;
                        issue_last_reg <= (LAST_ADDR == '0);
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_reg       <= addr_reg + 1'b1;
                        issue_vld_reg  <= 1'b1;
                        issue_last_reg <= ((addr_reg + 1'b1) == LAST_ADDR);
                        if ((addr_reg + 1'b1) == LAST_ADDR) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The issue register itself covers the first cycle of latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_vld_next[gi]  = issue_vld_reg;
                assign tag_last_next[gi] = issue_last_reg;
            end else begin : g_tail
                assign tag_vld_next[gi]  = tag_vld_reg[gi-1];
                assign tag_last_next[gi] = tag_last_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_reg  <= '0;
            tag_last_reg <= '0;
        end else begin
            tag_vld_reg  <= tag_vld_next;
            tag_last_reg <= tag_last_next;
        end
    end

    assign push      = tag_vld_reg[RD_LAT-1];
    assign push_beat = {tag_last_reg[RD_LAT-1], (bank_reg ? bram_rd_data1 : bram_rd_data0)};

    coef_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (OCC_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .din        (push_beat),
        .pop        (pop),
        .dout       (head),
        .dout_valid (head_vld),
        .count      (fifo_count)
    );

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign bram_rd_addr = addr_reg;
    assign m_valid      = head_vld;
    assign m_data       = head.coef;
    assign m_last       = head_vld && head.last;

    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst_n)
        int'(credit_reg) >= int'(fifo_count));
endmodule

// File: tb/tb_pwm_result_streamer.sv
// Scoreboard bench for pwm_result_streamer with a two-stage BRAM model per bank.
module tb_pwm_result_streamer;
    import he_pkg::*;

    localparam int NB     = 1 << LOGN;
    localparam int BUDGET = 40000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            bank_sel = 1'b0;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] bram_rd_addr;
    logic [LOGQ-1:0] bram_rd_data0;
    logic [LOGQ-1:0] bram_rd_data1;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [LOGQ-1:0] m_data;
    logic            m_last;

    pwm_result_streamer #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bank_sel      (bank_sel),
        .busy          (busy),
        .done          (done),
        .bram_rd_addr  (bram_rd_addr),
        .bram_rd_data0 (bram_rd_data0),
        .bram_rd_data1 (bram_rd_data1),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last)
    );

    always #5 clk = ~clk;

    // BRAM model: address registered at t gives data during cycle t+2; contents {bank, index}.
    logic [LOGN-1:0] s1_reg, s2_reg;
    always @(posedge clk) begin
        s1_reg <= bram_rd_addr;
        s2_reg <= s1_reg;
    end
    assign bram_rd_data0 = {1'b0, {(LOGQ-1-LOGN){1'b0}}, s2_reg};
    assign bram_rd_data1 = {1'b1, {(LOGQ-1-LOGN){1'b0}}, s2_reg};

    int total = 0;
    int bad = 0;

    logic [LOGQ:0] exp_q[$];

    int mism, beats, lasts, done_cyc, first_vld_cyc, stab_err, max_occ;
    int done_pulses, issues, stall_issues, stall_addr, timed_out;
    logic post_busy;
    logic [LOGQ-1:0] beat5;

    task automatic do_start(input logic b);
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back({(i == NB - 1), b, (LOGQ-1)'(i)});
        end
        @(negedge clk);
        bank_sel = b;
        start = 1'b1;
    endtask

    // Drives m_ready, consumes beats against the scoreboard and records observations.
    task automatic stream(input int pct, input int stall, input int restart_beat, input int stop_beat);
        int c;
        logic st_pend, stalled;
        logic [LOGQ:0] prev, exp;
        mism = 0; beats = 0; lasts = 0; done_cyc = -1; first_vld_cyc = -1;
        stab_err = 0; max_occ = 0; done_pulses = 0; issues = 0; stall_issues = -1;
        stall_addr = -1; timed_out = 0; post_busy = 1'b1; beat5 = '0;
        st_pend = (restart_beat >= 0);
        stalled = 1'b0;
        prev = '0;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c > BUDGET) begin
                timed_out = 1;
                break;
            end
            if (int'(dut.u_fifo.count_reg) > max_occ) max_occ = int'(dut.u_fifo.count_reg);
            if (dut.issue_vld_reg) issues++;
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = c;
            if (stalled && (!m_valid || {m_last, m_data} !== prev)) stab_err++;
            if (c == stall) begin
                stall_addr = int'(bram_rd_addr);
                stall_issues = issues;
            end
            if (done_cyc >= 0) begin
                if (done) done_pulses++;
                if (c == done_cyc + 1) post_busy = busy;
                if (c >= done_cyc + 8) break;
            end else if (done) begin
                done_cyc = c;
                done_pulses++;
            end
            m_ready = (c <= stall) ? 1'b0 : (int'($urandom_range(99)) < pct);
            if (st_pend && beats == restart_beat) begin
                start = 1'b1;
                bank_sel = ~bank_sel;
                st_pend = 1'b0;
            end
            stalled = m_valid && !m_ready;
            prev = {m_last, m_data};
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    mism++;
                end else begin
                    exp = exp_q.pop_front();
                    if ({m_last, m_data} !== exp) mism++;
                end
                if (beats == 5) beat5 = m_data;
                if (m_last) lasts++;
                beats++;
                if (stop_beat > 0 && beats == stop_beat) break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%0h want=0", m_data); end
        total++; if (bram_rd_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bram_rd_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_full_rate();
        do_start(1'b0);
        stream(100, 0, -1, 0);
        total++; if (timed_out != 0) begin bad++; $display("FAIL full_timeout got=%0d want=0", timed_out); end
        total++; if (mism != 0) begin bad++; $display("FAIL full_order mismatches=%0d want=0", mism); end
        total++; if (beats != NB) begin bad++; $display("FAIL full_beats got=%0d want=%0d", beats, NB); end
        total++; if (lasts != 1) begin bad++; $display("FAIL full_last_count got=%0d want=1", lasts); end
        total++; if (done_cyc != NB + 4) begin bad++; $display("FAIL full_done_cycle got=%0d want=%0d", done_cyc, NB + 4); end
        total++; if (first_vld_cyc < 3) begin bad++; $display("FAIL full_first_valid got=%0d want>=3", first_vld_cyc); end
        total++; if (post_busy !== 1'b0) begin bad++; $display("FAIL full_busy_after_done got=%b want=0", post_busy); end
        total++; if (done_pulses != 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", done_pulses); end
        $display("full_rate: beats=%0d done_cycle=%0d", beats, done_cyc);
    endtask

    task automatic test_backpressure();
        do_start(1'b0);
        stream(30, 0, -1, 0);
        total++; if (timed_out != 0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", timed_out); end
        total++; if (mism != 0) begin bad++; $display("FAIL bp_order mismatches=%0d want=0", mism); end
        total++; if (beats != NB) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", beats, NB); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable_while_stalled got=%0d want=0", stab_err); end
        total++; if (max_occ > 4) begin bad++; $display("FAIL bp_max_occupancy got=%0d want<=4", max_occ); end
        total++; if (done_pulses != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", done_pulses); end
        $display("backpressure: beats=%0d done_cycle=%0d max_occ=%0d", beats, done_cyc, max_occ);
    endtask

    task automatic test_bank_sel();
        logic [LOGQ-1:0] want5;
        want5 = {1'b1, (LOGQ-1)'(5)};
        do_start(1'b1);
        stream(100, 0, -1, 0);
        total++; if (mism != 0) begin bad++; $display("FAIL bank1_order mismatches=%0d want=0", mism); end
        total++; if (beat5 !== want5) begin bad++; $display("FAIL bank1_beat5 got=%0h want=%0h", beat5, want5); end
        total++; if (done_cyc != NB + 4) begin bad++; $display("FAIL bank1_done_cycle got=%0d want=%0d", done_cyc, NB + 4); end
        $display("bank_sel: beats=%0d beat5=%0h", beats, beat5);
    endtask

    task automatic test_stall_release();
        do_start(1'b0);
        stream(100, 100, -1, 0);
        total++; if (stall_issues != 4) begin bad++; $display("FAIL stall_reads got=%0d want=4", stall_issues); end
        total++; if (stall_addr != 3) begin bad++; $display("FAIL stall_addr got=%0d want=3", stall_addr); end
        total++; if (mism != 0) begin bad++; $display("FAIL stall_order mismatches=%0d want=0", mism); end
        total++; if (beats != NB) begin bad++; $display("FAIL stall_beats got=%0d want=%0d", beats, NB); end
        $display("stall_release: reads_during_stall=%0d addr=%0d beats=%0d", stall_issues, stall_addr, beats);
    endtask

    task automatic test_mid_reset();
        do_start(1'b0);
        stream(100, 0, -1, 1000);
        total++; if (beats != 1000) begin bad++; $display("FAIL midrst_pre_beats got=%0d want=1000", beats); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_m_valid got=%b want=0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL midrst_m_data got=%0h want=0", m_data); end
        total++; if (bram_rd_addr !== '0) begin bad++; $display("FAIL midrst_addr got=%0d want=0", bram_rd_addr); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL midrst_m_last got=%b want=0", m_last); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0);
        stream(100, 0, -1, 0);
        total++; if (mism != 0) begin bad++; $display("FAIL midrst_restart_order mismatches=%0d want=0", mism); end
        total++; if (beats != NB) begin bad++; $display("FAIL midrst_restart_beats got=%0d want=%0d", beats, NB); end
        $display("mid_reset: restart beats=%0d done_cycle=%0d", beats, done_cyc);
    endtask

    task automatic test_start_busy();
        do_start(1'b0);
        stream(100, 0, 100, 0);
        total++; if (beats != NB) begin bad++; $display("FAIL busy_start_beats got=%0d want=%0d", beats, NB); end
        total++; if (done_pulses != 1) begin bad++; $display("FAIL busy_start_done_pulses got=%0d want=1", done_pulses); end
        total++; if (mism != 0) begin bad++; $display("FAIL busy_start_order mismatches=%0d want=0", mism); end
        $display("start_while_busy: beats=%0d done_pulses=%0d", beats, done_pulses);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_bank_sel();
        test_stall_release();
        test_mid_reset();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
